debounce_bank: RTL and testbench

Multi-channel button/switch debouncer with input synchronisation, one-cycle edge pulses and optional per-channel auto-repeat. It sits between the board pushbuttons and switches and the I/O-system register logic, replacing single-channel debouncer instances with one parametrised bank. Each channel is independent. Each channel produces a clean level, a rise pulse, a fall pulse, and a "press" pulse that can repeat while the input is held.

---
 rtl/debounce_bank.sv | 138 +++++++++++++
 tb/tb_debounce_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchroniser, stability counter, one-cycle
// rise/fall pulses and a per-channel auto-repeat "press" generator.
module debounce_bank #(
    parameter int CLK_FREQUENCY     = 100_000_000,
    parameter int DEBOUNCE_DELAY_US = 1_000,
    parameter int REPEAT_DELAY_US   = 500_000,
    parameter int REPEAT_PERIOD_US  = 100_000,
    parameter int NUM_CH            = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] din,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] press
);

    localparam int CYC_PER_US = CLK_FREQUENCY / 1_000_000;
    localparam int DB_CYCLES  = CYC_PER_US * DEBOUNCE_DELAY_US;
    localparam int RD_CYCLES  = CYC_PER_US * REPEAT_DELAY_US;
    localparam int RP_CYCLES  = CYC_PER_US * REPEAT_PERIOD_US;
    localparam int RT_MAX     = (RD_CYCLES > RP_CYCLES) ? RD_CYCLES : RP_CYCLES;
    localparam int DBW        = $clog2(DB_CYCLES + 1);
    localparam int RTW        = $clog2(RT_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [RTW-1:0] RD_LAST = RTW'(RD_CYCLES - 1);
    localparam logic [RTW-1:0] RP_LAST = RTW'(RP_CYCLES - 1);

    typedef enum logic {
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_e;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // NOTE: synchronous active-high reset; every register uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             s;
        logic [DBW-1:0]   db_cnt_q, db_cnt_d;
        logic             dout_q, dout_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic [RTW-1:0]   rpt_cnt_q, rpt_cnt_d;
        rpt_state_e       rpt_state_q, rpt_state_d;
        logic             press_q;
        logic             rpt_d;

        assign s = sync2_q[ch];

        // NOTE: every next-state signal is given a default first so no latch is inferred.
        always_comb begin
            db_cnt_d = '0;
            dout_d   = dout_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            if (s != dout_q) begin
                if (db_cnt_q == DB_LAST) begin
                    dout_d = s;
                    rise_d = s;
                    fall_d = ~s;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end
        end

        // A falling dout kills any repeat that would otherwise land with the fall.
        always_comb begin
            rpt_state_d = rpt_state_q;
            rpt_cnt_d   = rpt_cnt_q + RTW'(1);
            rpt_d       = 1'b0;
            if (!dout_q || !repeat_en[ch] || fall_d) begin
                rpt_state_d = RPT_DELAY;
                rpt_cnt_d   = '0;
            end else begin
                case (rpt_state_q)
                    RPT_DELAY: begin
                        if (rpt_cnt_q == RD_LAST) begin
                            rpt_d       = 1'b1;
                            rpt_cnt_d   = '0;
                            rpt_state_d = RPT_PERIOD;
                        end
                    end
                    RPT_PERIOD: begin
                        if (rpt_cnt_q == RP_LAST) begin
                            rpt_d     = 1'b1;
                            rpt_cnt_d = '0;
                        end
                    end
                    default: begin
                        rpt_state_d = RPT_DELAY;
                        rpt_cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q    <= '0;
                dout_q      <= 1'b0;
                rise_q      <= 1'b0;
                fall_q      <= 1'b0;
                rpt_cnt_q   <= '0;
                rpt_state_q <= RPT_DELAY;
                press_q     <= 1'b0;
            end else begin
                db_cnt_q    <= db_cnt_d;
                dout_q      <= dout_d;
                rise_q      <= rise_d;
                fall_q      <= fall_d;
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_state_q <= rpt_state_d;
                press_q     <= rise_d | rpt_d;
            end
        end

        assign dout[ch]  = dout_q;
        assign rise[ch]  = rise_q;
        assign fall[ch]  = fall_q;
        assign press[ch] = press_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and randomised bench for debounce_bank, checked every cycle against a
// history-based reference model plus hand-derived timing checkpoints.
module tb_debounce_bank;

    localparam int CLK_HZ  = 1_000_000;
    localparam int DEB_US  = 10;
    localparam int RD_US   = 50;
    localparam int RP_US   = 20;
    localparam int NCH     = 4;
    localparam int DB      = CLK_HZ / 1_000_000 * DEB_US;
    localparam int RD      = CLK_HZ / 1_000_000 * RD_US;
    localparam int RP      = CLK_HZ / 1_000_000 * RP_US;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] din;
    logic [NCH-1:0] repeat_en;
    logic [NCH-1:0] dout;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] press;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state, valid for the cycle after the most recent clock edge.
    bit [NCH-1:0] m_dout, m_rise, m_fall, m_press;
    bit [NCH-1:0] m_s1, m_s2;
    bit [DB-1:0]  m_hist [NCH];
    int           m_run  [NCH];

    debounce_bank #(
        .CLK_FREQUENCY    (CLK_HZ),
        .DEBOUNCE_DELAY_US(DEB_US),
        .REPEAT_DELAY_US  (RD_US),
        .REPEAT_PERIOD_US (RP_US),
        .NUM_CH           (NCH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .repeat_en(repeat_en),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .press    (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // dout flips once the last DB synchronised samples all disagree with it; a repeat
    // fires when dout has been high with repeat enabled for RD + k*RP whole cycles.
    task automatic model_advance();
        if (rst) begin
            m_dout = '0; m_rise = '0; m_fall = '0; m_press = '0;
            m_s1 = '0; m_s2 = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_hist[ch] = '0;
                m_run[ch]  = 0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                bit prev, nxt, all_diff, rep;
                prev       = m_dout[ch];
                m_hist[ch] = {m_hist[ch][DB-2:0], m_s2[ch]};
                all_diff   = prev ? (m_hist[ch] == '0) : (&m_hist[ch]);
                nxt        = all_diff ? ~prev : prev;
                if (prev && repeat_en[ch]) m_run[ch]++;
                else m_run[ch] = 0;
                rep = nxt && (m_run[ch] >= RD) && ((m_run[ch] - RD) % RP == 0);
                m_rise[ch]  = nxt & ~prev;
                m_fall[ch]  = ~nxt & prev;
                m_press[ch] = (nxt & ~prev) | rep;
                m_dout[ch]  = nxt;
            end
            m_s2 = m_s1;
            m_s1 = din;
        end
    endtask

    // Each cycle: compare at the falling edge, advance the model, then drive just after
    // the next rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check($sformatf("cyc%0d dout", cyc), dout, m_dout);
            check($sformatf("cyc%0d rise", cyc), rise, m_rise);
            check($sformatf("cyc%0d fall", cyc), fall, m_fall);
            check($sformatf("cyc%0d press", cyc), press, m_press);
            model_advance();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        repeat_en = '0;
        @(posedge clk);
        #1;
        step(2);
        check("reset dout", dout, 4'b0000);
        check("reset rise", rise, 4'b0000);
        check("reset fall", fall, 4'b0000);
        check("reset press", press, 4'b0000);
        rst = 1'b0;
        step(3);

        // Clean press/release on ch0, no auto-repeat.
        din[0] = 1'b1;
        step(11);
        check("t1 dout before latency", dout, 4'b0000);
        step(1);
        check("t1 dout at k+12", dout, 4'b0001);
        check("t1 rise at k+12", rise, 4'b0001);
        check("t1 press at k+12", press, 4'b0001);
        step(1);
        check("t1 rise one cycle", rise, 4'b0000);
        check("t1 press one cycle", press, 4'b0000);
        step(40);
        din[0] = 1'b0;
        step(12);
        check("t1 fall dout", dout, 4'b0000);
        check("t1 fall pulse", fall, 4'b0001);
        step(1);
        check("t1 fall one cycle", fall, 4'b0000);
        step(5);

        // Bounce rejection on ch1: 5-high / 3-low, four times.
        repeat (4) begin
            din[1] = 1'b1;
            step(5);
            din[1] = 1'b0;
            step(3);
        end
        check("t2 bounce dout", dout, 4'b0000);
        din[1] = 1'b1;
        step(11);
        check("t2 dout before latency", dout, 4'b0000);
        step(1);
        check("t2 rise after hold", rise, 4'b0010);
        step(20);
        din[1] = 1'b0;
        step(20);

        // Auto-repeat on ch2, with a short glitch while held that must not disturb timing.
        repeat_en = 4'b0100;
        din[2] = 1'b1;
        step(12);
        check("t3 rise r", rise, 4'b0100);
        check("t3 press r", press, 4'b0100);
        step(20);
        din[2] = 1'b0;
        step(3);
        din[2] = 1'b1;
        step(26);
        check("t3 no press r+49", press, 4'b0000);
        step(1);
        check("t3 press r+50", press, 4'b0100);
        check("t3 no rise r+50", rise, 4'b0000);
        step(20);
        check("t3 press r+70", press, 4'b0100);
        step(20);
        check("t3 press r+90", press, 4'b0100);
        step(20);
        check("t3 press r+110", press, 4'b0100);
        step(8);
        din[2] = 1'b0;
        step(11);
        check("t3 dout r+129", dout, 4'b0100);
        step(1);
        check("t3 fall r+130", fall, 4'b0100);
        check("t3 no press at fall", press, 4'b0000);
        step(30);

        // Repeat enable dropped at r+60 and restored at r+80 restarts the full delay.
        din[2] = 1'b1;
        step(12);
        check("t4 rise r", rise, 4'b0100);
        step(50);
        check("t4 press r+50", press, 4'b0100);
        step(10);
        repeat_en[2] = 1'b0;
        step(10);
        check("t4 no press r+70", press, 4'b0000);
        step(10);
        repeat_en[2] = 1'b1;
        step(49);
        check("t4 no press r+129", press, 4'b0000);
        step(1);
        check("t4 press r+130", press, 4'b0100);
        step(20);
        check("t4 press r+150", press, 4'b0100);
        step(2);
        din[2] = 1'b0;
        step(40);

        // All channels together.
        repeat_en = '0;
        din = 4'b1111;
        step(12);
        check("t5 rise all", rise, 4'b1111);
        check("t5 press all", press, 4'b1111);
        step(5);
        din = 4'b0000;
        step(12);
        check("t5 fall all", fall, 4'b1111);
        step(3);

        // Reset mid-repeat on ch2 and mid-count (count 7) on ch0.
        repeat_en = 4'b0100;
        din = 4'b0100;
        step(72);
        din = 4'b0101;
        step(9);
        rst = 1'b1;
        step(1);
        check("t6 reset dout", dout, 4'b0000);
        check("t6 reset rise", rise, 4'b0000);
        check("t6 reset press", press, 4'b0000);
        rst = 1'b0;
        step(11);
        check("t6 dout before latency", dout, 4'b0000);
        step(1);
        check("t6 rise after reset", rise, 4'b0101);
        check("t6 press after reset", press, 4'b0101);
        step(50);
        check("t6 repeat after reset", press, 4'b0100);
        din = '0;
        step(20);

        // Random phase A: fast bouncing, occasional enable changes and resets.
        repeat (800) begin
            rst = ($urandom_range(499) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(9) == 0) din[ch] = ~din[ch];
                if ($urandom_range(59) == 0) repeat_en[ch] = ~repeat_en[ch];
            end
            step(1);
        end
        rst = 1'b0;

        // Random phase B: long holds so auto-repeat gets exercised.
        repeat_en = 4'b1111;
        repeat (1500) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(89) == 0) din[ch] = ~din[ch];
                if ($urandom_range(299) == 0) repeat_en[ch] = ~repeat_en[ch];
            end
            step(1);
        end
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
